mult_unit: RTL and testbench

Iterative 32x32 multiplier for the execute stage. It owns the HI/LO register pair and implements MULT, MULTU, MTHI and MTLO. It drives `busy_multE` into the hazard detector, which stalls F/D and flushes E while `start_multE` or `busy_multE` is high. It consumes the forwarded E-stage operands `srcaE` and `srcbE` and supplies `hi` and `lo` to the MFHI/MFLO result mux.

---
 rtl/mult_unit_if.sv | 33 +++
 rtl/mult_unit.sv | 112 +++++++++++
 tb/tb_mult_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_unit_if.sv
// Execute-stage multiplier port bundle.
// Pipeline side is master, mult_unit is slave.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_multE;
  logic             signed_multE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             hi_weE;
  logic             lo_weE;
  logic [WIDTH-1:0] wdataE;
  logic             busy_multE;
  logic             done_mult;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_multE, signed_multE,
    output srcaE, srcbE,
    output hi_weE, lo_weE, wdataE,
    input  busy_multE, done_mult,
    input  hi, lo
  );

  modport slave (
    input  start_multE, signed_multE,
    input  srcaE, srcbE,
    input  hi_weE, lo_weE, wdataE,
    output busy_multE, done_mult,
    output hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier owning HI/LO.
// MULT_EARLY_TERM_EN: finish once the multiplier is exhausted.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mult_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [2*WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0]   mplr, mplr_n;
  logic [CW-1:0]      count, count_n;
  logic               neg, neg_n;
  logic [WIDTH-1:0]   hi_q, hi_n;
  logic [WIDTH-1:0]   lo_q, lo_n;
  logic               done_q, done_n;

  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               last;
  logic               sa, sb;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      count  <= '0;
      neg    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplr   <= mplr_n;
      count  <= count_n;
      neg    <= neg_n;
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mcand_n = mcand;
    mplr_n  = mplr;
    count_n = count;
    neg_n   = neg;
    hi_n    = hi_q;
    lo_n    = lo_q;
    done_n  = 1'b0;

    sa    = bus.signed_multE & bus.srcaE[WIDTH-1];
    sb    = bus.signed_multE & bus.srcbE[WIDTH-1];
    // Most negative value maps to itself, read as unsigned.
    abs_a = sa ? -bus.srcaE : bus.srcaE;
    abs_b = sb ? -bus.srcbE : bus.srcbE;

    sum  = acc + (mplr[0] ? mcand : '0);
    prod = neg ? -sum : sum;
    last = (count == CW'(1));
`ifdef MULT_EARLY_TERM_EN
    last = last | (mplr[WIDTH-1:1] == '0);
`endif

    unique case (state)
      IDLE: begin
        if (bus.start_multE) begin
          mcand_n = {{WIDTH{1'b0}}, abs_a};
          mplr_n  = abs_b;
          neg_n   = sa ^ sb;
          acc_n   = '0;
          count_n = CW'(WIDTH);
          state_n = RUN;
        end else begin
          if (bus.hi_weE) hi_n = bus.wdataE;
          if (bus.lo_weE) lo_n = bus.wdataE;
        end
      end
      RUN: begin
        acc_n   = sum;
        mcand_n = mcand << 1;
        mplr_n  = mplr >> 1;
        count_n = count - CW'(1);
        if (last) begin
          {hi_n, lo_n} = prod;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy_multE = (state == RUN);
  assign bus.done_mult  = done_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit.
// Directed table, corner sequences and random ops vs a model.
module tb_mult_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_unit_if #(.WIDTH(32)) bus ();

  mult_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tbl[7];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(bit s,
      logic [31:0] a, logic [31:0] b);
    longint sp;
    if (s) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int exp_busy(bit s, logic [31:0] b);
    logic [31:0] m;
    int n;
    m = (s && b[31]) ? -b : b;
    n = 32;
`ifdef MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < 32; i++)
      if (m[i]) n = i + 1;
`endif
    return n;
  endfunction

  task automatic mt(bit h, bit l, logic [31:0] d);
    @(negedge clk);
    bus.hi_weE = h;
    bus.lo_weE = l;
    bus.wdataE = d;
    @(negedge clk);
    bus.hi_weE = 1'b0;
    bus.lo_weE = 1'b0;
  endtask

  task automatic run_op(string name, bit s,
      logic [31:0] a, logic [31:0] b,
      logic [63:0] exp, int inj, bit wr);
    int n;
    bit held;
    logic [31:0] hh, hl;
    @(negedge clk);
    hh = bus.hi;
    hl = bus.lo;
    bus.start_multE  = 1'b1;
    bus.signed_multE = s;
    bus.srcaE        = a;
    bus.srcbE        = b;
    bus.hi_weE       = wr;
    bus.lo_weE       = wr;
    bus.wdataE       = $urandom;
    @(negedge clk);
    bus.start_multE = 1'b0;
    bus.hi_weE      = 1'b0;
    bus.lo_weE      = 1'b0;
    n    = 0;
    held = 1'b1;
    while (bus.busy_multE && n < 100) begin
      n++;
      if (bus.hi !== hh || bus.lo !== hl) held = 1'b0;
      if (n == inj) begin
        bus.start_multE = 1'b1;
        bus.srcaE       = 32'd100;
        bus.srcbE       = 32'd100;
        bus.hi_weE      = 1'b1;
        bus.wdataE      = 32'hDEAD;
      end else begin
        bus.start_multE = 1'b0;
        bus.hi_weE      = 1'b0;
      end
      @(negedge clk);
    end
    bus.start_multE = 1'b0;
    bus.hi_weE      = 1'b0;
    check({name, " busy"}, 64'(n), 64'(exp_busy(s, b)));
    check({name, " hold"}, 64'(held), 64'd1);
    check({name, " done"}, 64'(bus.done_mult), 64'd1);
    check({name, " hilo"}, {bus.hi, bus.lo}, exp);
    @(negedge clk);
    check({name, " done_off"}, 64'(bus.done_mult), 64'd0);
  endtask

  initial begin
    int n;
    bit s;
    logic [31:0] a, b, d;
    checks = 0;
    errors = 0;
    bus.start_multE  = 1'b0;
    bus.signed_multE = 1'b0;
    bus.srcaE        = '0;
    bus.srcbE        = '0;
    bus.hi_weE       = 1'b0;
    bus.lo_weE       = 1'b0;
    bus.wdataE       = '0;

    tbl[0] = '{"multu_max", 1'b0, 32'hFFFFFFFF,
               32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
    tbl[1] = '{"mult_m3x7", 1'b1, 32'hFFFFFFFD,
               32'd7, 64'hFFFFFFFF_FFFFFFEB};
    tbl[2] = '{"mult_minsq", 1'b1, 32'h80000000,
               32'h80000000, 64'h40000000_00000000};
    tbl[3] = '{"mult_minx1", 1'b1, 32'h80000000,
               32'd1, 64'hFFFFFFFF_80000000};
    tbl[4] = '{"multu_1234x5", 1'b0, 32'd1234,
               32'd5, 64'd6170};
    tbl[5] = '{"multu_9x0", 1'b0, 32'd9,
               32'd0, 64'd0};
    tbl[6] = '{"mult_negneg", 1'b1, 32'hFFFFFFFE,
               32'hFFFFFFFB, 64'd10};

    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst busy", 64'(bus.busy_multE), 64'd0);
    check("rst done", 64'(bus.done_mult), 64'd0);
    check("rst hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b0;

    mt(1'b1, 1'b0, 32'h1234);
    check("mthi", 64'(bus.hi), 64'h1234);
    mt(1'b0, 1'b1, 32'h5678);
    check("mtlo", {bus.hi, bus.lo},
          64'h00001234_00005678);
    mt(1'b1, 1'b1, 32'hA5A5);
    check("mt_both", {bus.hi, bus.lo},
          64'h0000A5A5_0000A5A5);

    foreach (tbl[i])
      run_op(tbl[i].name, tbl[i].s, tbl[i].a,
             tbl[i].b, tbl[i].p, 0, 1'b0);

    mt(1'b1, 1'b0, 32'hCAFE);
    n = (exp_busy(1'b0, 32'd7) > 5) ? 5 : 2;
    run_op("ignore", 1'b0, 32'd6, 32'd7,
           64'h00000000_0000002A, n, 1'b0);

    mt(1'b1, 1'b1, 32'h77);
    @(negedge clk);
    bus.start_multE = 1'b1;
    bus.srcaE       = 32'h10000;
    bus.srcbE       = 32'h10000;
    @(negedge clk);
    bus.start_multE = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    check("midrst busy_pre", 64'(bus.busy_multE), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst busy", 64'(bus.busy_multE), 64'd0);
    check("midrst hilo", {bus.hi, bus.lo}, 64'd0);
    check("midrst done", 64'(bus.done_mult), 64'd0);
    @(negedge clk);
    check("midrst done2", 64'(bus.done_mult), 64'd0);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 2) == 0)
        b = b >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom;
        mt(1'b1, 1'b1, d);
        check("rnd_mt", {bus.hi, bus.lo}, {d, d});
      end
      run_op("rnd", s, a, b, ref_prod(s, a, b), 0,
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
